// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - Register-file instruction sequencer; REGFILE_CTRL_FLAGS_EN enables the ZERO/CARRY flags
module regfile_ctrl (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       INSTR_VALID,
    output logic       INSTR_READY,
    input  logic [2:0] OPCODE,
    input  logic [2:0] DR,
    input  logic [2:0] SA,
    input  logic [2:0] SB,
    input  logic [7:0] IMM,
    output logic [2:0] RF_SA,
    output logic [2:0] RF_SB,
    input  logic [7:0] RF_DATA_A,
    input  logic [7:0] RF_DATA_B,
    output logic       RF_LD,
    output logic [2:0] RF_DR,
    output logic [7:0] RF_DIN,
    output logic [7:0] RESULT,
    output logic       DONE,
    output logic       ZERO,
    output logic       CARRY
);

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       read_en;
    logic       exec_en;

    logic [2:0] op_q;
    logic [2:0] dr_q;
    logic [7:0] imm_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] alu_res;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fixed four-step walk per instruction
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (INSTR_VALID) state_nxt = S_READ;
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: handshake and per-phase load enables
    always_comb begin
        INSTR_READY = 1'b0;
        accept      = 1'b0;
        read_en     = 1'b0;
        exec_en     = 1'b0;
        case (state)
            S_IDLE: begin
                INSTR_READY = 1'b1;
                accept      = INSTR_VALID;
            end
            S_READ:  read_en = 1'b1;
            S_EXEC:  exec_en = 1'b1;
            default: ;
        endcase
    end

    // ALU result from the latched operands
    always_comb begin
        alu_res = 8'd0;
        case (op_q)
            OP_MOVI: alu_res = imm_q;
            OP_MOV:  alu_res = a_q;
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SHL:  alu_res = {a_q[6:0], 1'b0};
            default: alu_res = 8'd0;
        endcase
    end

    // Instruction capture, operand latch and registered write-port outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q   <= 3'd0;
            dr_q   <= 3'd0;
            imm_q  <= 8'd0;
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            RF_SA  <= 3'd0;
            RF_SB  <= 3'd0;
            RF_LD  <= 1'b0;
            RF_DR  <= 3'd0;
            RF_DIN <= 8'd0;
            RESULT <= 8'd0;
            DONE   <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= OPCODE;
                dr_q  <= DR;
                imm_q <= IMM;
                RF_SA <= SA;
                RF_SB <= SB;
            end
            if (read_en) begin
                a_q <= RF_DATA_A;
                b_q <= RF_DATA_B;
            end
            if (exec_en) begin
                RF_DR  <= dr_q;
                RF_DIN <= alu_res;
                RESULT <= alu_res;
            end
            // Write strobe lives exactly for the WRITE cycle
            RF_LD <= exec_en;
            DONE  <= exec_en;
        end
    end

`ifdef REGFILE_CTRL_FLAGS_EN
    logic flag_upd;
    logic alu_c;

    // Carry/borrow/shift-out; MOV and MOVI leave flags alone
    always_comb begin
        flag_upd = 1'b1;
        alu_c    = 1'b0;
        case (op_q)
            OP_MOVI, OP_MOV: flag_upd = 1'b0;
            OP_ADD:          alu_c = (9'(a_q) + 9'(b_q)) > 9'd255;
            OP_SUB:          alu_c = a_q < b_q;
            OP_SHL:          alu_c = a_q[7];
            default:         alu_c = 1'b0;
        endcase
    end

    // Flag registers, updated at the end of EXEC
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ZERO  <= 1'b0;
            CARRY <= 1'b0;
        end else if (exec_en && flag_upd) begin
            ZERO  <= (alu_res == 8'd0);
            CARRY <= alu_c;
        end
    end
`else
    assign ZERO  = 1'b0;
    assign CARRY = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - Randomized self-checking bench for regfile_ctrl with register-file and reference models
module tb_regfile_ctrl;

`ifdef REGFILE_CTRL_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic [2:0] OPCODE;
    logic [2:0] DR;
    logic [2:0] SA;
    logic [2:0] SB;
    logic [7:0] IMM;
    logic [2:0] RF_SA;
    logic [2:0] RF_SB;
    logic [7:0] RF_DATA_A;
    logic [7:0] RF_DATA_B;
    logic       RF_LD;
    logic [2:0] RF_DR;
    logic [7:0] RF_DIN;
    logic [7:0] RESULT;
    logic       DONE;
    logic       ZERO;
    logic       CARRY;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int ld_count = 0;

    logic [7:0] rf [8];
    int         ref_rf [8];
    bit         ref_z = 1'b0;
    bit         ref_c = 1'b0;

    regfile_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .OPCODE      (OPCODE),
        .DR          (DR),
        .SA          (SA),
        .SB          (SB),
        .IMM         (IMM),
        .RF_SA       (RF_SA),
        .RF_SB       (RF_SB),
        .RF_DATA_A   (RF_DATA_A),
        .RF_DATA_B   (RF_DATA_B),
        .RF_LD       (RF_LD),
        .RF_DR       (RF_DR),
        .RF_DIN      (RF_DIN),
        .RESULT      (RESULT),
        .DONE        (DONE),
        .ZERO        (ZERO),
        .CARRY       (CARRY)
    );

    always #5 CLK = ~CLK;

    // Register file the sequencer drives: combinational read, write on the edge, shared reset
    assign RF_DATA_A = rf[RF_SA];
    assign RF_DATA_B = rf[RF_SB];
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
        end else if (RF_LD) begin
            rf[RF_DR] <= RF_DIN;
        end
    end

    // Count write strobes seen
    always @(negedge CLK) begin
        if (RF_LD) ld_count++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU written from the operation table with plain integer arithmetic
    function automatic void model(input int op, input int a, input int b, input int imm,
                                  output int res, output bit c, output bit upd);
        upd = (op >= 2);
        c   = 1'b0;
        case (op)
            0: res = imm;
            1: res = a;
            2: begin res = (a + b) % 256; c = (a + b) > 255; end
            3: begin res = (a - b + 256) % 256; c = (a < b); end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            default: begin res = (a * 2) % 256; c = (a >= 128); end
        endcase
    endfunction

    task automatic run_instr(input int op, input int dr, input int sa, input int sb, input int imm,
                             input bit noise, output int din_o, output int z_o, output int c_o);
        int n;
        int er;
        bit ec;
        bit eupd;
        OPCODE = 3'(op); DR = 3'(dr); SA = 3'(sa); SB = 3'(sb); IMM = 8'(imm);
        INSTR_VALID = 1'b1;
        n = 0;
        while (!INSTR_READY && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check("ready_wait", int'(INSTR_READY), 1);
        model(op, ref_rf[sa], ref_rf[sb], imm, er, ec, eupd);
        if (eupd && FLAGS_ON) begin
            ref_z = (er == 0);
            ref_c = ec;
        end
        n_acc++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            if (noise) begin
                OPCODE = 3'($urandom); DR = 3'($urandom); SA = 3'($urandom);
                SB = 3'($urandom); IMM = 8'($urandom);
                INSTR_VALID = 1'b1;
            end else begin
                INSTR_VALID = 1'b0;
            end
            check("busy_ready", int'(INSTR_READY), 0);
            if (k < 3) check("early_ld", int'(RF_LD), 0);
        end
        check("wr_ld", int'(RF_LD), 1);
        check("wr_done", int'(DONE), 1);
        check("wr_dr", int'(RF_DR), dr);
        check("wr_din", int'(RF_DIN), er);
        check("wr_result", int'(RESULT), er);
        check("wr_zero", int'(ZERO), int'(ref_z));
        check("wr_carry", int'(CARRY), int'(ref_c));
        din_o = int'(RF_DIN);
        z_o   = int'(ZERO);
        c_o   = int'(CARRY);
        ref_rf[dr] = er;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        check("post_ld", int'(RF_LD), 0);
        check("post_done", int'(DONE), 0);
        check("post_ready", int'(INSTR_READY), 1);
        check("post_result", int'(RESULT), er);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, int'(INSTR_READY), 1);
        check({tag, "_ld"}, int'(RF_LD), 0);
        check({tag, "_done"}, int'(DONE), 0);
        check({tag, "_din"}, int'(RF_DIN), 0);
        check({tag, "_dr"}, int'(RF_DR), 0);
        check({tag, "_sa"}, int'(RF_SA), 0);
        check({tag, "_sb"}, int'(RF_SB), 0);
        check({tag, "_result"}, int'(RESULT), 0);
        check({tag, "_zero"}, int'(ZERO), 0);
        check({tag, "_carry"}, int'(CARRY), 0);
    endtask

    initial begin
        int din;
        int z;
        int c;
        int acc_before;

        RESET = 1'b1; INSTR_VALID = 1'b0;
        OPCODE = 3'd0; DR = 3'd0; SA = 3'd0; SB = 3'd0; IMM = 8'd0;
        for (int i = 0; i < 8; i++) ref_rf[i] = 0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_outputs("rst");

        run_instr(0, 3, 0, 0, 8'h5A, 1'b0, din, z, c);
        check("movi_din", din, 8'h5A);

        run_instr(0, 1, 0, 0, 8'hF0, 1'b0, din, z, c);
        run_instr(0, 2, 0, 0, 8'h20, 1'b0, din, z, c);
        run_instr(2, 4, 1, 2, 0, 1'b0, din, z, c);
        check("add_din", din, 8'h10);
        check("add_carry", c, FLAGS_ON ? 1 : 0);
        check("add_zero", z, 0);

        run_instr(3, 5, 2, 1, 0, 1'b0, din, z, c);
        check("sub_din", din, 8'h30);
        check("sub_borrow", c, FLAGS_ON ? 1 : 0);
        run_instr(6, 6, 1, 1, 0, 1'b0, din, z, c);
        check("xor_din", din, 0);
        check("xor_zero", z, FLAGS_ON ? 1 : 0);
        check("xor_carry", c, 0);
        run_instr(1, 7, 6, 0, 0, 1'b0, din, z, c);
        check("mov_keeps_zero", z, FLAGS_ON ? 1 : 0);

        run_instr(0, 1, 0, 0, 8'h81, 1'b0, din, z, c);
        run_instr(7, 1, 1, 0, 0, 1'b0, din, z, c);
        check("shl_din", din, 8'h02);
        check("shl_carry", c, FLAGS_ON ? 1 : 0);
        run_instr(1, 0, 1, 0, 0, 1'b0, din, z, c);
        check("mov_after_shl", din, 8'h02);

        // Abort an ADD in EXEC: no write, everything back to reset values
        acc_before = ld_count;
        OPCODE = 3'd2; DR = 3'd4; SA = 3'd1; SB = 3'd2; IMM = 8'd0;
        INSTR_VALID = 1'b1;
        check("abort_ready", int'(INSTR_READY), 1);
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_outputs("abort");
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) ref_rf[i] = 0;
        ref_z = 1'b0;
        ref_c = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort_ready_after", int'(INSTR_READY), 1);
        check("abort_no_ld", ld_count, acc_before);

        for (int t = 0; t < 40; t++) begin
            run_instr(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                      int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                      int'($urandom_range(255, 0)), bit'($urandom_range(1, 0)), din, z, c);
        end
        repeat (4) @(negedge CLK);
        check("ld_pulses", ld_count, n_acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
